// File: rtl/pll_clken_gen.sv
// PLL lock qualifier and NUM_CH programmable clock-enable/square-wave dividers; run after 1+LOCK_DLY edges of lock.
// Outputs are registered decodes of each cycle's counter; no backpressure, div_ld is always accepted.
module pll_clken_gen #(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int DEF_DIV  = 4,
  parameter int LOCK_DLY = 1024,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              locked,
  input  logic              div_ld,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              run,
  output logic              rst_out,
  output logic [NUM_CH-1:0] clken,
  output logic [NUM_CH-1:0] clkout
);

  localparam int SET_W = $clog2(LOCK_DLY + 1);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(LOCK_DLY);
  localparam logic [SET_W-1:0] SET_ONE = SET_W'(1);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DEF_V   = DIV_W'(DEF_DIV);
  localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic             sync1;
  logic             lk_s;
  logic [SET_W-1:0] settle_q;
  logic [SET_W-1:0] settle_d;
  logic             run_q;
  logic             run_d;
  logic [CH_W:0]    ch_ext;
  logic             ch_ok;

  // sync1 is the value lk_s takes next, so a drop clears run on the edge lk_s falls
  always_comb begin
    settle_d = settle_q;
    if (!sync1)
      settle_d = '0;
    else if (lk_s && (settle_q != SET_MAX))
      settle_d = settle_q + SET_ONE;
    run_d = sync1 && (settle_d == SET_MAX);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      lk_s     <= 1'b0;
      settle_q <= '0;
      run_q    <= 1'b0;
    end else begin
      sync1    <= locked;
      lk_s     <= sync1;
      settle_q <= settle_d;
      run_q    <= run_d;
    end
  end

  assign ch_ext  = {1'b0, div_ch};
  assign ch_ok   = ch_ext < NUM_CH_V;
  assign run     = run_q;
  assign rst_out = ~run_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] act_q;
    logic [DIV_W-1:0] act_d;
    logic [DIV_W-1:0] pend_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] eff;
    logic [DIV_W-1:0] eff_d;
    logic [DIV_W-1:0] half_d;
    logic             pv_q;
    logic             pv_d;
    logic             wrap;
    logic             xfer;
    logic             ld_hit;
    logic             clken_q;
    logic             clkout_q;

    assign ld_hit = div_ld && ch_ok && (div_ch == CH_W'(i));

    // outputs are decoded from next-state values so the flops show this cycle's cnt/run
    always_comb begin
      eff    = (act_q == '0) ? ONE : act_q;
      wrap   = run_q && (cnt_q == eff - ONE);
      xfer   = pv_q && (wrap || !run_q);
      act_d  = xfer ? pend_q : act_q;
      eff_d  = (act_d == '0) ? ONE : act_d;
      half_d = (eff_d >> 1) + {{(DIV_W-1){1'b0}}, eff_d[0]};
      cnt_d  = cnt_q + ONE;
      if (!run_d || !run_q || wrap)
        cnt_d = '0;
      pv_d   = ld_hit || (pv_q && !xfer);
    end

    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        act_q    <= DEF_V;
        pend_q   <= '0;
        pv_q     <= 1'b0;
        cnt_q    <= '0;
        clken_q  <= 1'b0;
        clkout_q <= 1'b0;
      end else begin
        act_q    <= act_d;
        pv_q     <= pv_d;
        cnt_q    <= cnt_d;
        clken_q  <= run_d && (cnt_d == eff_d - ONE);
        clkout_q <= run_d && (cnt_d < half_d);
        if (ld_hit)
          pend_q <= div_val;
      end
    end

    assign clken[i]  = clken_q;
    assign clkout[i] = clkout_q;
  end

endmodule

// File: doc/pll_clken_gen.md
# pll_clken_gen

Multi-channel clock-enable generator that sits directly behind the board PLL. It qualifies the PLL `locked` signal and releases a synchronous downstream reset after a programmable settle time. It then produces NUM_CH independent divided clock-enable pulses and square-wave outputs from the single PLL output clock. Each channel's divide ratio is run-time programmable and changes glitch-free at the channel's wrap boundary.

## Interface
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 16, width of each channel's divide value
- DEF_DIV, 4, divide value loaded into every channel at reset
- LOCK_DLY, 1024, consecutive synchronized-locked cycles required before run (≥1)
- refclk  in  1  sole clock (PLL output clock); all logic on rising edge
- rst  in  1  asynchronous, active-high reset; clears all state
- locked  in  1  PLL lock indicator, asynchronous to refclk
- div_ld  in  1  one-cycle strobe: load div_val into channel div_ch
- div_ch  in  $clog2(NUM_CH) (min 1)  target channel index for div_ld
- div_val  in  DIV_W  new divide value D
- run  out  1  high when lock is qualified and channels are running
- rst_out  out  1  active-high synchronous reset for downstream logic, equal to ~run
- clken  out  NUM_CH  per-channel one-cycle enable pulse, period D cycles
- clkout  out  NUM_CH  per-channel divided square wave, period D cycles

## Operation
- Lock qualification: `locked` passes through a 2-flop synchronizer to produce lk_s. A settle counter increments while lk_s=1 and saturates at LOCK_DLY. Reaching LOCK_DLY sets run=1.
- Loss of lock: lk_s=0 clears the settle counter and run on the same edge. It also zeroes all channel counters, clken and clkout. Divide registers (active and pending) are retained.
- Per channel i: active divide A_i, pending divide P_i with a valid flag, and counter cnt_i (DIV_W bits).
- Effective divide E_i = (A_i==0) ? 1 : A_i. A value of 0 behaves as 1.
- While run=1, cnt_i counts 0..E_i−1 and wraps to 0.
- clken_i=1 exactly in the cycle where cnt_i==E_i−1.
- clkout_i=1 while cnt_i < ceil(E_i/2). E=1 gives constant 1. E=2 gives a 50% duty output. E=3 gives 2 high / 1 low.
- clken and clkout are flop outputs, so they are glitch-free. In any cycle they equal the decode of that cycle's cnt_i and run.
- Loading: div_ld with div_ch<NUM_CH writes P_i=div_val and sets valid. div_ld with div_ch≥NUM_CH is ignored.
  - If run=1, P_i transfers to A_i on the wrap edge (cnt_i==E_i−1 → 0). The new period starts at cnt=0, so no truncated or runt cycle occurs.
  - If run=0, P_i transfers to A_i on the next edge.
  - A second load before the transfer overwrites P_i; last write wins.
  - A load coinciding with the wrap edge lands in P_i and applies at the following wrap.
- All channels start phase-aligned (cnt=0) in the first run cycle.

## Timing
- Reset values: run=0, rst_out=1, clken=0, clkout=0, cnt=0, A_i=DEF_DIV, P_i invalid, settle counter=0, synchronizer=0.
- Lock latency: let edge 0 be the first refclk edge at which `locked` is sampled high. Then lk_s=1 after edge 1, and run=1, rst_out=0 after edge 1+LOCK_DLY. This requires `locked` to stay high throughout.
- Lock-drop latency: run falls 2 edges after `locked` falls, because of the synchronizer depth.
- Channel startup: in the first cycle with run=1, cnt=0 and clkout=1. clken first pulses in cycle E−1 counted from that cycle, then every E cycles.
- Load latency while running: the new period takes effect at the next wrap boundary after the div_ld edge, worst case E_old cycles.
- Asynchronous rst mid-operation forces all outputs to their reset values immediately. Operation restarts with the full lock latency after rst deasserts.

## Test plan
- Reset with locked=1 held, LOCK_DLY=8 → run rises exactly 9 edges after the first locked sample. rst_out mirrors it. All channels start aligned at cnt=0.
- DEF_DIV=4, run=1 → clken pulses on cycles 3, 7, 11. clkout pattern is 1100 repeating on every channel.
- Load ch1 D=3 mid-period (cnt=1, A=4) → the old period completes. Next periods: clkout 110, clken every 3rd cycle, with no runt pulse. Other channels are unaffected.
- Load D=0 and D=1 → clken high every cycle and clkout constant 1. Load with div_ch=NUM_CH → no register changes.
- Deassert locked for 1 cycle while running → run falls 2 edges later and outputs zero. Re-lock waits the full LOCK_DLY. Divide values are preserved.
- Two loads to ch0 (5, then 7) before a wrap, plus a load landing on the wrap edge → 7 applies at the first wrap, and the edge-coincident value applies at the next wrap.
